// File: rtl/input_conditioner.sv
// Two-flop synchronizer, per-bit debounce and per-key press FSM for switches/keys.
// Optional auto-repeat on held keys is enabled by defining INPUT_CONDITIONER_REPEAT_EN.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] SW_raw,
    input  logic [3:0] KEY_raw,
    output logic [9:0] SW_out,
    output logic [3:0] KEY_out,
    output logic [3:0] KEY_press,
    output logic       sw_changed
);

    localparam int unsigned NB = 14;
    localparam logic [NB-1:0] RST_VAL = {4'hf, 10'h000};
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (HOLD_CYCLES < 1 || 64'(HOLD_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_hold
        $error("HOLD_CYCLES out of range for CNT_W");
    end
    if (REPEAT_CYCLES < 1 || 64'(REPEAT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_repeat
        $error("REPEAT_CYCLES out of range for CNT_W");
    end

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} key_state_t;

    logic [NB-1:0]    raw, sync1, sync2, stable, flip;
    logic [CNT_W-1:0] db_cnt [NB];
    logic [3:0]       key_fall, key_rise;
    key_state_t       key_state [4];
`ifdef INPUT_CONDITIONER_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] hold_cnt [4];
`endif

    assign raw     = {KEY_raw, SW_raw};
    assign SW_out  = stable[9:0];
    assign KEY_out = stable[13:10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // flip marks the bits whose stable value changes on the coming edge, so the
    // pulses below can be registered on that very edge.
    always_comb begin
        flip = '0;
        for (int unsigned i = 0; i < NB; i++)
            flip[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end

    assign key_fall = flip[13:10] & stable[13:10];
    assign key_rise = flip[13:10] & ~stable[13:10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= RST_VAL;
            for (int unsigned i = 0; i < NB; i++)
                db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (flip[i]) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sw_changed <= 1'b0;
        else
            sw_changed <= |flip[9:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            KEY_press <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                key_state[k] <= IDLE;
`ifdef INPUT_CONDITIONER_REPEAT_EN
                hold_cnt[k] <= '0;
`endif
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                KEY_press[k] <= 1'b0;
                case (key_state[k])
                    IDLE: begin
                        if (key_fall[k]) begin
                            KEY_press[k] <= 1'b1;
                            key_state[k] <= HOLD;
`ifdef INPUT_CONDITIONER_REPEAT_EN
                            hold_cnt[k]  <= '0;
`endif
                        end
                    end
                    HOLD: begin
                        if (key_rise[k]) begin
                            key_state[k] <= IDLE;
`ifdef INPUT_CONDITIONER_REPEAT_EN
                            hold_cnt[k]  <= '0;
                        end else if (hold_cnt[k] == HOLD_LAST) begin
                            KEY_press[k] <= 1'b1;
                            key_state[k] <= REPEAT;
                            hold_cnt[k]  <= '0;
                        end else begin
                            hold_cnt[k]  <= hold_cnt[k] + 1'b1;
`endif
                        end
                    end
                    REPEAT: begin
                        if (key_rise[k]) begin
                            key_state[k] <= IDLE;
`ifdef INPUT_CONDITIONER_REPEAT_EN
                            hold_cnt[k]  <= '0;
                        end else if (hold_cnt[k] == REP_LAST) begin
                            KEY_press[k] <= 1'b1;
                            hold_cnt[k]  <= '0;
                        end else begin
                            hold_cnt[k]  <= hold_cnt[k] + 1'b1;
`endif
                        end
                    end
                    default: key_state[k] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronizes and debounces the raw DE-board slide switches and push-buttons before they reach the input manager, which splits them into mode-select and data inputs for SAP1, the RAM controller and the clock manager. Every input bit passes through a two-flop synchronizer and a per-bit stability counter. The block also produces one-cycle key-press pulses, so the manual clock step and RAM write strobes see exactly one event per physical press.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive cycles an input must differ from its debounced value before the output flips (10 ms at 50 MHz); legal range 1..2^CNT_W-1.
- HOLD_CYCLES, 25000000: cycles a key must stay pressed before auto-repeat starts (used only with the repeat feature).
- REPEAT_CYCLES, 5000000: auto-repeat pulse period (used only with the repeat feature).
- CNT_W, 25: width of every internal counter; must hold the largest cycle parameter.
- clk  in  1  system clock; all logic is single-clock.
- rst  in  1  asynchronous, active-high reset.
- SW_raw  in  10  raw slide switches; bits 9:8 are the master-mode select downstream.
- KEY_raw  in  4  raw push-buttons, active-low (0 = pressed).
- SW_out  out  10  debounced switches, same polarity as SW_raw.
- KEY_out  out  4  debounced keys, active-low, same polarity as KEY_raw.
- KEY_press  out  4  one-cycle active-high press pulse per key.
- sw_changed  out  1  one-cycle pulse in any cycle where any SW_out bit changes.

## Operation
- Reset values: SW_out = 10'h000, KEY_out = 4'hf (released), KEY_press = 0, sw_changed = 0. Synchronizer flops reset to the same values as the outputs. All counters reset to 0 and all key FSMs reset to IDLE.
- Synchronizer: 2 flops per bit, 14 bits in total; no logic between the two stages.
- Debounce, per bit: the counter clears whenever the synced value equals the stable value.
  - On a mismatch, the counter increments.
  - On a mismatch with the counter at DEBOUNCE_CYCLES-1, the stable value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES leaves the output unchanged.
  - Counter arithmetic is unsigned CNT_W. The counter cannot wrap, because it clears at the terminal count.
- Key FSM, one per key, with states IDLE, HOLD and REPEAT:
  - IDLE -> HOLD when the debounced KEY_out bit falls 1->0. KEY_press pulses on that same edge and the hold counter clears.
  - HOLD and REPEAT -> IDLE as soon as KEY_out returns to 1. No pulse is produced and the counter clears.
  - Without the repeat feature, HOLD is terminal until release.
- sw_changed is the registered OR of per-bit change flags. It is asserted on the same edge that updates SW_out.
- Keys are independent: simultaneous presses on several keys produce simultaneous pulses on the corresponding bits.
- Reset asserted mid-debounce or mid-hold discards all progress. A key still held after reset is debounced again from scratch.

## Timing
- Input-to-output latency: 2 + DEBOUNCE_CYCLES edges, counted from the first edge that samples the new pin level.
- KEY_press and sw_changed are high for exactly 1 cycle. Both are coincident with the edge that updates KEY_out / SW_out.
- Outputs are registered; there is no combinational path from the raw inputs to any output.
- Minimum spacing between two pulses from separate presses: 2*DEBOUNCE_CYCLES cycles (release, then press).

## Configuration
- Macro: INPUT_CONDITIONER_REPEAT_EN.
- Defined:
  - In HOLD, when the counter reaches HOLD_CYCLES-1, the block pulses KEY_press, clears the counter and enters REPEAT.
  - In REPEAT, KEY_press pulses every REPEAT_CYCLES cycles until release.
- Undefined:
  - Exactly one KEY_press pulse per debounced press.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored, and the repeat counters are not synthesized.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, CNT_W=8.
- Reset: assert rst with SW_raw=10'h3ff and KEY_raw=4'h0 -> outputs are SW_out=0, KEY_out=4'hf and no pulses. Release rst -> SW_out=10'h3ff and KEY_out=4'h0 after 6 edges, with sw_changed and KEY_press=4'hf each high for 1 cycle.
- Bounce: toggle KEY_raw[0] every 2 cycles for 20 cycles, then hold it at 0 -> KEY_out[0] falls exactly 6 edges after the final toggle, with a single KEY_press[0] pulse.
- Glitch: drive SW_raw[3] high for 3 cycles -> SW_out and sw_changed never change.
- Simultaneous: press KEY[1] and KEY[3] on the same cycle -> KEY_press=4'b1010 for 1 cycle.
- Repeat: hold KEY_raw[2]=0 for 30 cycles.
  - With the macro: pulses at debounce, then at +10, then every 3 cycles.
  - Without the macro: exactly 1 pulse.
  - On release, no pulse.
- Reset mid-hold: assert rst during HOLD -> no pulse, and after rst is released a fresh 6-edge debounce is required.
